// File: rtl/local_history_table_pkg.sv
// Shared types and helpers for the per-branch local history table.
package lht_pkg;

    // Widest PC, index and history the helpers handle; callers cast down.
    localparam int unsigned LHT_PC_MAX    = 64;
    localparam int unsigned LHT_INDEX_MAX = 32;
    localparam int unsigned LHT_HIST_MAX  = 32;

    typedef enum logic {
        LHT_INIT = 1'b0,
        LHT_RUN  = 1'b1
    } lht_state_t;

    // Word-address index; the caller truncates to its INDEX_WIDTH,
    // which yields pc[INDEX_WIDTH+1:2].
    function automatic logic [LHT_INDEX_MAX-1:0] lht_index(input logic [LHT_PC_MAX-1:0] pc);
        return LHT_INDEX_MAX'(pc >> 2);
    endfunction

    // Shift one outcome into the LSB of a history word.
    function automatic logic [LHT_HIST_MAX-1:0] shift_in(input logic [LHT_HIST_MAX-1:0] hist,
                                                         input logic                    bit_in);
        return (hist << 1) | LHT_HIST_MAX'(bit_in);
    endfunction

endpackage

// File: rtl/local_history_table_init_sweeper.sv
// Init sweeper: clears one table entry per cycle after reset or flush,
// then holds the table in RUN with ready asserted.
module lht_init_sweeper
    import lht_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    output logic                   ready,
    output logic                   sweep_we,
    output logic [INDEX_WIDTH-1:0] sweep_idx
);

    localparam int unsigned            DEPTH = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0]   LAST  = (INDEX_WIDTH + 1)'(DEPTH - 1);
    localparam logic [INDEX_WIDTH:0]   ONE   = (INDEX_WIDTH + 1)'(1);

    lht_state_t             state;
    logic [INDEX_WIDTH:0]   cnt;

    // Sweep FSM: INIT walks cnt over every entry, RUN waits for a flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LHT_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                LHT_INIT: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= LHT_RUN;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                LHT_RUN: begin
                    if (flush) begin
                        state <= LHT_INIT;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign sweep_we  = (state == LHT_INIT);
    assign sweep_idx = cnt[INDEX_WIDTH-1:0];

endmodule

// File: rtl/local_history_table.sv
// Per-branch local history table: speculative shift at fetch, repair or
// allocate at resolve, write-first read bypass, swept clear on init.
module local_history_table
    import lht_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned HIST_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic                  ready,
    input  logic [PC_WIDTH-1:0]   rd_pc,
    output logic                  rd_hit,
    output logic [HIST_WIDTH-1:0] rd_history,
    input  logic                  spec_valid,
    input  logic [PC_WIDTH-1:0]   spec_pc,
    input  logic                  spec_taken,
    input  logic                  res_valid,
    input  logic [PC_WIDTH-1:0]   res_pc,
    input  logic                  res_taken,
    input  logic                  res_mispred,
    input  logic [HIST_WIDTH-1:0] res_history,
    output logic [HIST_WIDTH-1:0] upd_history
);

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

    // Storage deliberately has no reset; the sweeper clears it.
    logic [HIST_WIDTH-1:0]  hist_mem [DEPTH];
    logic [DEPTH-1:0]       valid_mem;

    logic                   sweep_we;
    logic [INDEX_WIDTH-1:0] sweep_idx;

    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [INDEX_WIDTH-1:0] spec_idx;
    logic [INDEX_WIDTH-1:0] res_idx;

    logic                   spec_req;
    logic                   res_req;
    logic                   spec_we;
    logic                   res_we;
    logic [HIST_WIDTH-1:0]  spec_new;

    lht_init_sweeper #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_sweeper (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .ready     (ready),
        .sweep_we  (sweep_we),
        .sweep_idx (sweep_idx)
    );

    assign rd_idx   = INDEX_WIDTH'(lht_index(LHT_PC_MAX'(rd_pc)));
    assign spec_idx = INDEX_WIDTH'(lht_index(LHT_PC_MAX'(spec_pc)));
    assign res_idx  = INDEX_WIDTH'(lht_index(LHT_PC_MAX'(res_pc)));

    assign upd_history = HIST_WIDTH'(shift_in(LHT_HIST_MAX'(res_history), res_taken));

    // Speculative value: shift into a live entry, or start fresh on a cold one.
    always_comb begin
        spec_new = HIST_WIDTH'(spec_taken);
        if (valid_mem[spec_idx]) begin
            spec_new = HIST_WIDTH'(shift_in(LHT_HIST_MAX'(hist_mem[spec_idx]), spec_taken));
        end
    end

    // Write arbitration: repair beats a wrong-path spec shift, while a plain
    // allocate yields to spec when both hit the same entry.
    always_comb begin
        spec_req = ready & spec_valid;
        res_req  = ready & res_valid & (res_mispred | ~valid_mem[res_idx]);
        spec_we  = spec_req;
        res_we   = res_req;
        if (spec_req && res_req && (spec_idx == res_idx)) begin
            if (res_mispred) begin
                spec_we = 1'b0;
            end else begin
                res_we = 1'b0;
            end
        end
    end

    // Table update: sweep clear in INIT, arbitrated spec/res writes in RUN.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            valid_mem[sweep_idx] <= 1'b0;
            hist_mem[sweep_idx]  <= '0;
        end
        if (spec_we) begin
            valid_mem[spec_idx] <= 1'b1;
            hist_mem[spec_idx]  <= spec_new;
        end
        if (res_we) begin
            valid_mem[res_idx] <= 1'b1;
            hist_mem[res_idx]  <= upd_history;
        end
    end

    // Write-first lookup; nothing is visible until the sweep has finished.
    always_comb begin
        rd_hit     = 1'b0;
        rd_history = '0;
        if (ready) begin
            if (res_we && (res_idx == rd_idx)) begin
                rd_hit     = 1'b1;
                rd_history = upd_history;
            end else if (spec_we && (spec_idx == rd_idx)) begin
                rd_hit     = 1'b1;
                rd_history = spec_new;
            end else if (valid_mem[rd_idx]) begin
                rd_hit     = 1'b1;
                rd_history = hist_mem[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_local_history_table.sv
// Self-checking bench for local_history_table (default parameters).
module tb_local_history_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        ready;
    logic [31:0] rd_pc;
    logic        rd_hit;
    logic [3:0]  rd_history;
    logic        spec_valid;
    logic [31:0] spec_pc;
    logic        spec_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic        res_taken;
    logic        res_mispred;
    logic [3:0]  res_history;
    logic [3:0]  upd_history;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       rdy;
        logic       hit;
        logic [3:0] hist;
        logic [3:0] upd;
    } exp_t;

    typedef struct {
        logic        sv;
        logic [31:0] spc;
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        rt;
        logic        rm;
        logic [3:0]  rh;
        logic [31:0] rdpc;
        logic        hit;
        logic [3:0]  hist;
    } vec_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    local_history_table #(
        .PC_WIDTH    (32),
        .INDEX_WIDTH (8),
        .HIST_WIDTH  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .ready       (ready),
        .rd_pc       (rd_pc),
        .rd_hit      (rd_hit),
        .rd_history  (rd_history),
        .spec_valid  (spec_valid),
        .spec_pc     (spec_pc),
        .spec_taken  (spec_taken),
        .res_valid   (res_valid),
        .res_pc      (res_pc),
        .res_taken   (res_taken),
        .res_mispred (res_mispred),
        .res_history (res_history),
        .upd_history (upd_history)
    );

    function automatic vec_t row(logic sv, logic [31:0] spc, logic st,
                                 logic rv, logic [31:0] rpc, logic rt, logic rm, logic [3:0] rh,
                                 logic [31:0] rdpc, logic hit, logic [3:0] hist);
        vec_t v;
        v.sv = sv; v.spc = spc; v.st = st;
        v.rv = rv; v.rpc = rpc; v.rt = rt; v.rm = rm; v.rh = rh;
        v.rdpc = rdpc; v.hit = hit; v.hist = hist;
        return v;
    endfunction

    function automatic void push(string n, logic r, logic h, logic [3:0] hs, logic [3:0] u);
        exp_t e;
        e.name = n; e.rdy = r; e.hit = h; e.hist = hs; e.upd = u;
        exp_q.push_back(e);
    endfunction

    task automatic apply(input vec_t v);
        spec_valid  = v.sv;
        spec_pc     = v.spc;
        spec_taken  = v.st;
        res_valid   = v.rv;
        res_pc      = v.rpc;
        res_taken   = v.rt;
        res_mispred = v.rm;
        res_history = v.rh;
        rd_pc       = v.rdpc;
    endtask

    task automatic idle_inputs;
        flush       = 1'b0;
        spec_valid  = 1'b0;
        spec_pc     = '0;
        spec_taken  = 1'b0;
        res_valid   = 1'b0;
        res_pc      = '0;
        res_taken   = 1'b0;
        res_mispred = 1'b0;
        res_history = '0;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd_pc = $urandom;
            push("reset_held", 1'b0, 1'b0, 4'h0, 4'h0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, i, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            rd_pc = $urandom;
            push("reset_release", 1'(k == 256), 1'b0, 4'h0, 4'h0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s edge %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, k, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
        end
    endtask

    task automatic test_spec_shift;
        vec_t t[8];
        exp_t e;
        t[0] = row(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h40,  1'b1, 4'b0001);
        t[1] = row(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h40,  1'b1, 4'b0011);
        t[2] = row(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h40,  1'b1, 4'b0110);
        t[3] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h40,  1'b1, 4'b0110);
        t[4] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h44,  1'b0, 4'b0000);
        t[5] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h440, 1'b1, 4'b0110);
        t[6] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h42,  1'b1, 4'b0110);
        t[7] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0,   1'b0, 4'b0000);
        foreach (t[i]) begin
            apply(t[i]);
            push("spec_shift", 1'b1, t[i].hit, t[i].hist, {t[i].rh[2:0], t[i].rt});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s row %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, i, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_repair;
        vec_t t[7];
        exp_t e;
        t[0] = row(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 4'b0011, 32'h40, 1'b1, 4'b0110);
        t[1] = row(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 4'b1000, 32'h40, 1'b1, 4'b0001);
        t[2] = row(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h40, 1'b1, 4'b0001);
        t[3] = row(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 4'b1111, 32'h40, 1'b1, 4'b0001);
        t[4] = row(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h40, 1'b1, 4'b0001);
        t[5] = row(1'b0, 32'h0, 1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 4'b0101, 32'h48, 1'b1, 4'b1010);
        t[6] = row(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h48, 1'b1, 4'b1010);
        foreach (t[i]) begin
            apply(t[i]);
            push("repair", 1'b1, t[i].hit, t[i].hist, {t[i].rh[2:0], t[i].rt});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s row %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, i, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_collision;
        vec_t t[9];
        exp_t e;
        t[0] = row(1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 4'b0101, 32'h80, 1'b1, 4'b1010);
        t[1] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h80, 1'b1, 4'b1010);
        t[2] = row(1'b1, 32'h80, 1'b1, 1'b1, 32'h84, 1'b1, 1'b1, 4'b0110, 32'h84, 1'b1, 4'b1101);
        t[3] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h80, 1'b1, 4'b0101);
        t[4] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h84, 1'b1, 4'b1101);
        t[5] = row(1'b1, 32'h8C, 1'b1, 1'b1, 32'h8C, 1'b1, 1'b0, 4'b0111, 32'h8C, 1'b1, 4'b0001);
        t[6] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h8C, 1'b1, 4'b0001);
        t[7] = row(1'b1, 32'h80, 1'b0, 1'b1, 32'h84, 1'b0, 1'b1, 4'b0000, 32'h80, 1'b1, 4'b1010);
        t[8] = row(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 4'b0000, 32'h84, 1'b1, 4'b0000);
        foreach (t[i]) begin
            apply(t[i]);
            push("collision", 1'b1, t[i].hit, t[i].hist, {t[i].rh[2:0], t[i].rt});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s row %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, i, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_flush;
        exp_t e;
        flush      = 1'b1;
        spec_valid = 1'b1;
        spec_pc    = 32'h40;
        spec_taken = 1'b1;
        rd_pc      = 32'h40;
        push("flush_cycle", 1'b1, 1'b1, 4'b0011, 4'b0000);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
            errors++;
            $display("FAIL %s: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                     e.name, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        for (int k = 1; k <= 256; k++) begin
            spec_valid  = 1'($urandom);
            spec_pc     = $urandom;
            spec_taken  = 1'($urandom);
            res_valid   = 1'($urandom);
            res_pc      = ($urandom_range(0, 1) != 0) ? spec_pc : $urandom;
            res_taken   = 1'($urandom);
            res_mispred = 1'($urandom);
            res_history = 4'($urandom);
            rd_pc       = (k == 1) ? 32'h40 : (($urandom_range(0, 1) != 0) ? spec_pc : res_pc);
            push("flush_sweep", 1'b0, 1'b0, 4'h0, {res_history[2:0], res_taken});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s cycle %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, k, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
        for (int i = 0; i < 256; i++) begin
            rd_pc = {22'($urandom), 8'(i), 2'($urandom)};
            push("flush_cleared", 1'b1, 1'b0, 4'h0, 4'h0);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s index %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, i, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midsweep;
        exp_t e;
        spec_valid = 1'b1;
        spec_pc    = 32'h40;
        spec_taken = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_pc = 32'h40;
        push("pre_reset", 1'b1, 1'b1, 4'b0001, 4'h0);
        push("reset_async", 1'b0, 1'b0, 4'h0, 4'h0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
            errors++;
            $display("FAIL %s: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                     e.name, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
        end
        reset = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
            errors++;
            $display("FAIL %s: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                     e.name, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            push("partial_sweep", 1'b0, 1'b0, 4'h0, 4'h0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s edge %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, k, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            push("restart_sweep", 1'(k == 256), 1'b0, 4'h0, 4'h0);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            checks++;
            if ({ready, rd_hit, rd_history, upd_history} !== {e.rdy, e.hit, e.hist, e.upd}) begin
                errors++;
                $display("FAIL %s edge %0d: got ready=%b hit=%b hist=%b upd=%b want ready=%b hit=%b hist=%b upd=%b",
                         e.name, k, ready, rd_hit, rd_history, upd_history, e.rdy, e.hit, e.hist, e.upd);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by time limit, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        rd_pc = '0;
        idle_inputs();
        #1;
        reset = 1'b0;
        test_reset();
        test_spec_shift();
        test_repair();
        test_collision();
        test_flush();
        test_reset_midsweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/local_history_table.md
# local_history_table

Parametrised per-branch local history table for the branch predictor, indexed by PC word-address bits. It supports a speculative shift at predict time and a repair/allocate write at branch resolution, and exposes the pre-update history for pattern-table training. The history/valid storage is a non-reset array that an init sweeper clears one entry per cycle, after reset and on request. It sits between fetch (lookup, speculative update) and the ID/EX resolve stage (repair).

## Interface
- PC_WIDTH, 32, width of all PC inputs
- INDEX_WIDTH, 8, table index bits; index = pc[INDEX_WIDTH+1:2]
- HIST_WIDTH, 4, history bits per entry (>=2)
- DEPTH, 1<<INDEX_WIDTH, entry count (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  request table re-initialisation
- ready  out  1  1 = table usable; 0 during sweep
- rd_pc  in  PC_WIDTH  fetch lookup PC
- rd_hit  out  1  indexed entry valid
- rd_history  out  HIST_WIDTH  history of indexed entry, 0 if not hit
- spec_valid  in  1  speculative update strobe (predicted branch at fetch)
- spec_pc  in  PC_WIDTH  PC of predicted branch
- spec_taken  in  1  predicted direction
- res_valid  in  1  branch resolved in EX
- res_pc  in  PC_WIDTH  PC of resolved branch
- res_taken  in  1  actual direction
- res_mispred  in  1  prediction was wrong
- res_history  in  HIST_WIDTH  history captured at predict time, piped with the branch
- upd_history  out  HIST_WIDTH  {res_history[HIST_WIDTH-2:0], res_taken}, combinational

## Operation
- States: INIT (sweeping), RUN.
- Reset asserted: state=INIT, sweep counter=0, ready=0, rd_hit=0, rd_history=0.
- INIT: each edge writes valid[cnt]=0 and hist[cnt]=0, then cnt++.
  - After writing cnt=DEPTH-1, go to RUN.
  - Counter is INDEX_WIDTH+1 bits wide, so there is no wrap ambiguity.
  - spec/res writes are dropped; rd_hit=0 and rd_history=0.
- flush in RUN: the next edge enters INIT with cnt=0. flush in INIT restarts cnt at 0.
- RUN, spec_valid: entry index(spec_pc).
  - Valid entry: hist <= {hist[H-2:0], spec_taken}.
  - Invalid entry: hist <= {0…, spec_taken}, valid <= 1.
- RUN, res_valid:
  - res_mispred=1: hist[index(res_pc)] <= upd_history, valid <= 1 (repair).
  - res_mispred=0 and entry invalid: allocate with upd_history.
  - res_mispred=0 and entry valid: no write, since the speculative shift already applied.
- Same-edge collision, same index:
  - Repair (mispred) wins; the spec write belongs to the wrong path and is discarded.
  - A non-mispred allocate loses to spec.
  - Different indices: both writes happen.
- Read bypass (write-first): if a RUN write targets index(rd_pc) this cycle, rd_hit=1 and rd_history shows the value being written (winning write per collision rule).
- upd_history is valid regardless of state; it is qualified by res_valid externally.

## Timing
- rd_hit/rd_history: combinational from rd_pc, zero-cycle latency.
- Writes take effect at the clock edge; visible to a non-bypassed read the following cycle.
- Reset release to ready=1: exactly DEPTH rising edges. ready rises after the edge that clears entry DEPTH-1.
- flush latency: ready falls after the edge sampling flush; returns DEPTH edges later.
- Reset asserted mid-sweep or mid-RUN: immediate INIT, cnt=0. Stale array contents are never visible because rd_hit=0 until the sweep completes.
- No backpressure: spec/res strobes are single-cycle and fire-and-forget. The upstream gates them with ready.

## Structure
- Package lht_pkg:
  - state enum {LHT_INIT, LHT_RUN}.
  - Function lht_index(pc) returning pc[INDEX_WIDTH+1:2].
  - Function shift_in(hist, bit).
- Sub-module lht_init_sweeper: FSM plus counter. Outputs ready, sweep_we, sweep_idx.
- Top holds the arrays, collision priority and read bypass.
- Arrays have no reset and map to distributed RAM/flops; only FSM/counter flops connect to reset.

## Test plan
- Reset, release, DEPTH=256: ready=0 for 256 edges, 1 after edge 256. Any rd_pc gives rd_hit=0, rd_history=0 throughout.
- spec_valid, pc=0x40, taken=1,1,0 on three cycles: rd_pc=0x40 gives rd_history=4'b0110, rd_hit=1. Same-cycle read of 0x40 during the third write shows 4'b0110 via bypass.
- Entry 0x40=4'b0110, res_valid, mispred=1, res_history=4'b0011, taken=0: upd_history=4'b0110; entry becomes 4'b0110.
- Same edge, spec to 0x80 (taken=1) and repair to 0x80 (upd_history=4'b1010): entry=4'b1010. With repair to 0x84 instead, both entries are written.
- flush in RUN mid-traffic: ready=0 next cycle, spec/res ignored, all entries rd_hit=0 after ready returns (256 edges).
- Reset pulsed at sweep cnt=100: sweep restarts from 0; ready rises 256 edges after release.
